sdram_rw_arbiter: RTL
=====================

# sdram_rw_arbiter

Schedules the single SDRAM_TOP request port (CLK_100M domain) between the write path (write FIFO → SDRAM) and the read path (SDRAM → read FIFO). Monitors FIFO fill levels, raises SDRAM_WR_REQ or SDRAM_RD_REQ one burst at a time, and drives SDRAM_ADDR_IN from independent circular write and read pointers. Tracks SDRAM occupancy so reads never overtake writes and writes never overrun unread data. Round-robin when both paths are eligible.

## Interface
- ADDR_W, 22, SDRAM word-address width; pointers wrap modulo 2^ADDR_W
- BURST_LEN, 8, words per SDRAM access; power of two, ≤ 256
- FIFO_DEPTH, 256, depth of the read FIFO in words
- USEDW_W, 9, width of the FIFO used-word inputs
- TIMEOUT, 1024, cycles REQ may wait for ACK (used only with ARB_TIMEOUT_EN)

- CLK_100M  in  1  system/SDRAM controller clock
- RST  in  1  asynchronous, active-high reset
- WR_FIFO_USEDW  in  USEDW_W  words waiting in the write FIFO
- RD_FIFO_USEDW  in  USEDW_W  words held in the read FIFO
- RD_ENABLE  in  1  read path permitted to fetch (level)
- FLUSH  in  1  clear pointers and occupancy (level, sampled in IDLE)
- SDRAM_WR_ACK  in  1  high for exactly BURST_LEN cycles during a write burst
- SDRAM_RD_ACK  in  1  high for exactly BURST_LEN cycles during a read burst
- SDRAM_WR_REQ  out  1  write burst request
- SDRAM_RD_REQ  out  1  read burst request
- SDRAM_ADDR_IN  out  ADDR_W  burst start address
- LEVEL  out  ADDR_W+1  words written but not yet read back
- BUSY  out  1  high in any state except IDLE
- ERR  out  1  sticky ACK-timeout flag

## Operation
- States: IDLE, WR_REQ, WR_XFER, RD_REQ, RD_XFER, DONE.
- Write eligible: WR_FIFO_USEDW ≥ BURST_LEN and LEVEL ≤ 2^ADDR_W − BURST_LEN.
- Read eligible: RD_ENABLE and LEVEL ≥ BURST_LEN and RD_FIFO_USEDW ≤ FIFO_DEPTH − BURST_LEN.
- IDLE: FLUSH high → wr_ptr, rd_ptr, LEVEL cleared, stay IDLE (no grant that cycle). Else if both eligible, grant the path not granted last (last_grant resets to READ, so first contention goes to WRITE). Else grant whichever is eligible. Else stay.
- WR_REQ: SDRAM_WR_REQ=1, SDRAM_ADDR_IN=wr_ptr; go to WR_XFER on SDRAM_WR_ACK=1 (REQ drops that same transition).
- WR_XFER: wait for SDRAM_WR_ACK falling; then wr_ptr += BURST_LEN (mod 2^ADDR_W), LEVEL += BURST_LEN, go DONE.
- RD_REQ / RD_XFER: symmetric, using rd_ptr; on completion rd_ptr += BURST_LEN, LEVEL −= BURST_LEN.
- DONE: one cycle, update last_grant, return to IDLE.
- SDRAM_WR_REQ and SDRAM_RD_REQ never both high. ACKs arriving in IDLE, DONE, or on the non-granted path are ignored.
- FLUSH asserted outside IDLE has no effect until IDLE is reached.

## Timing
- Reset values: SDRAM_WR_REQ=0, SDRAM_RD_REQ=0, SDRAM_ADDR_IN=0, LEVEL=0, BUSY=0, ERR=0; pointers 0, state IDLE.
- All outputs registered. REQ rises 1 cycle after the eligibility condition is sampled in IDLE.
- SDRAM_ADDR_IN becomes valid the cycle REQ rises and holds until DONE.
- REQ falls the cycle after ACK is first seen high.
- Pointer and LEVEL update visible the cycle after ACK falls (DONE entry). Minimum REQ-to-REQ gap is 2 cycles after ACK falls.
- Pointer wrap: ADDR = 2^ADDR_W − BURST_LEN advances to 0 with no extra cycle.
- Reset mid-burst: immediate return to reset values. The SDRAM controller is reset by the same source.

## Configuration
- ARB_TIMEOUT_EN defined: a counter runs in WR_REQ and RD_REQ. After TIMEOUT cycles without ACK, REQ drops, ERR sets (sticky until RST), state returns to IDLE, and pointers and LEVEL are unchanged.
- ARB_TIMEOUT_EN undefined: REQ waits indefinitely and ERR is tied 0.

## Test plan
- Write-only burst: WR_FIFO_USEDW=8, RD_ENABLE=0 → WR_REQ with ADDR 0x000000. After 8-cycle ACK, LEVEL=8. Next burst uses ADDR 0x000008.
- Contention: both paths eligible with last_grant=WRITE → RD_REQ first, then WR_REQ. The two REQs never overlap.
- Read gating: LEVEL=0, RD_ENABLE=1 → no RD_REQ. RD_FIFO_USEDW=250 with LEVEL=16 → no RD_REQ until USEDW ≤ 248.
- Wrap: force wr_ptr=0x3FFFF8, complete a burst → wr_ptr=0x000000. LEVEL increments by 8 with no glitch.
- FLUSH during WR_XFER → burst completes (LEVEL=8), then cleared in IDLE: LEVEL=0, next ADDR 0.
- Timeout (ARB_TIMEOUT_EN): hold ACK low → REQ drops after 1024 cycles, ERR=1, LEVEL unchanged. Without the macro, REQ stays high.

Source files
------------

// File: rtl/sdram_rw_arbiter_if.sv
// ---------------------------------------------------------------------------
// sdram_rw_arbiter_if
//   Groups the FIFO-level inputs, the control levels and the SDRAM request /
//   acknowledge handshake of the SDRAM read/write arbiter.
//
//   master : the arbiter (drives requests, address and status)
//   slave  : FIFO logic + SDRAM controller side (drives levels and ACKs)
//
//   WR_FIFO_USEDW  words waiting in the write FIFO
//   RD_FIFO_USEDW  words held in the read FIFO
//   RD_ENABLE      read path permitted to fetch
//   FLUSH          clear pointers and occupancy (acted on in IDLE)
//   SDRAM_WR_ACK   high for one burst length during a write burst
//   SDRAM_RD_ACK   high for one burst length during a read burst
//   SDRAM_WR_REQ   write burst request
//   SDRAM_RD_REQ   read burst request
//   SDRAM_ADDR_IN  burst start address
//   LEVEL          words written but not yet read back
//   BUSY           arbiter not idle
//   ERR            sticky ACK-timeout flag
// ---------------------------------------------------------------------------
interface sdram_rw_arbiter_if #(
  parameter int ADDR_W  = 22,
  parameter int USEDW_W = 9
);
  logic [USEDW_W-1:0] WR_FIFO_USEDW;
  logic [USEDW_W-1:0] RD_FIFO_USEDW;
  logic               RD_ENABLE;
  logic               FLUSH;
  logic               SDRAM_WR_ACK;
  logic               SDRAM_RD_ACK;
  logic               SDRAM_WR_REQ;
  logic               SDRAM_RD_REQ;
  logic [ADDR_W-1:0]  SDRAM_ADDR_IN;
  logic [ADDR_W:0]    LEVEL;
  logic               BUSY;
  logic               ERR;

  modport master (
    input  WR_FIFO_USEDW, RD_FIFO_USEDW, RD_ENABLE, FLUSH,
           SDRAM_WR_ACK, SDRAM_RD_ACK,
    output SDRAM_WR_REQ, SDRAM_RD_REQ, SDRAM_ADDR_IN, LEVEL, BUSY, ERR
  );

  modport slave (
    output WR_FIFO_USEDW, RD_FIFO_USEDW, RD_ENABLE, FLUSH,
           SDRAM_WR_ACK, SDRAM_RD_ACK,
    input  SDRAM_WR_REQ, SDRAM_RD_REQ, SDRAM_ADDR_IN, LEVEL, BUSY, ERR
  );
endinterface

// File: rtl/sdram_rw_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_rw_arbiter
//   Shares the single SDRAM request port between the write path
//   (write FIFO -> SDRAM) and the read path (SDRAM -> read FIFO), one burst
//   at a time. Independent circular write/read pointers supply the burst
//   address; LEVEL tracks words written but not yet read so reads never
//   overtake writes and writes never overrun unread data. Round-robin when
//   both paths are eligible.
//
//   Ports:
//     CLK_100M  system / SDRAM controller clock
//     RST       asynchronous active-high reset
//     bus       sdram_rw_arbiter_if.master (FIFO levels, control, handshake)
//
//   Optional feature, macro ARB_TIMEOUT_EN:
//     defined   : a request waiting TIMEOUT cycles for ACK is withdrawn,
//                 ERR sets (sticky) and the arbiter returns to IDLE.
//     undefined : requests wait indefinitely, ERR is tied low.
// ---------------------------------------------------------------------------
module sdram_rw_arbiter #(
  parameter int ADDR_W     = 22,
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 256,
  parameter int USEDW_W    = 9,
  parameter int TIMEOUT    = 1024
) (
  input logic                CLK_100M,
  input logic                RST,
  sdram_rw_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_XFER, S_RD_REQ, S_RD_XFER, S_DONE
  } state_e;

  typedef enum logic { GRANT_RD = 1'b0, GRANT_WR = 1'b1 } grant_e;

  localparam logic [USEDW_W-1:0] USEDW_BURST  = USEDW_W'(BURST_LEN);
  localparam logic [USEDW_W-1:0] USEDW_RD_MAX = USEDW_W'(FIFO_DEPTH - BURST_LEN);
  localparam logic [ADDR_W:0]    LVL_BURST    = (ADDR_W+1)'(BURST_LEN);
  // Largest LEVEL that still leaves room for one more burst.
  localparam logic [ADDR_W:0]    LVL_WR_MAX   = ((ADDR_W+1)'(1) << ADDR_W) - LVL_BURST;
  localparam logic [ADDR_W-1:0]  PTR_BURST    = ADDR_W'(BURST_LEN);

  if (((BURST_LEN & (BURST_LEN - 1)) != 0) || (BURST_LEN > 256) || (TIMEOUT < 1))
  begin : g_bad_param
    $error("sdram_rw_arbiter: BURST_LEN must be a power of two <= 256, TIMEOUT >= 1");
  end

  state_e            state_q;
  grant_e            last_grant_q;
  grant_e            cur_grant_q;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   level_q;
  logic              wr_req_q;
  logic              rd_req_q;
  logic              busy_q;

`ifdef ARB_TIMEOUT_EN
  localparam int             TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            err_q;
`endif

  logic   wr_elig;
  logic   rd_elig;
  logic   grant_valid_d;
  grant_e grant_d;

  assign wr_elig = (bus.WR_FIFO_USEDW >= USEDW_BURST) && (level_q <= LVL_WR_MAX);
  assign rd_elig = bus.RD_ENABLE && (level_q >= LVL_BURST) &&
                   (bus.RD_FIFO_USEDW <= USEDW_RD_MAX);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    grant_valid_d = wr_elig | rd_elig;
    grant_d       = wr_elig ? GRANT_WR : GRANT_RD;
    // Contention: alternate, starting from the path not granted last.
    if (wr_elig && rd_elig) begin
      grant_d = (last_grant_q == GRANT_RD) ? GRANT_WR : GRANT_RD;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK_100M or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      last_grant_q <= GRANT_RD;
      cur_grant_q  <= GRANT_RD;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      addr_q       <= '0;
      level_q      <= '0;
      wr_req_q     <= 1'b0;
      rd_req_q     <= 1'b0;
      busy_q       <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      to_cnt_q     <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.FLUSH) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
          end else if (grant_valid_d) begin
            busy_q      <= 1'b1;
            cur_grant_q <= grant_d;
`ifdef ARB_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
            if (grant_d == GRANT_WR) begin
              state_q  <= S_WR_REQ;
              wr_req_q <= 1'b1;
              addr_q   <= wr_ptr_q;
            end else begin
              state_q  <= S_RD_REQ;
              rd_req_q <= 1'b1;
              addr_q   <= rd_ptr_q;
            end
          end
        end

        S_WR_REQ: begin
          if (bus.SDRAM_WR_ACK) begin
            wr_req_q <= 1'b0;
            state_q  <= S_WR_XFER;
          end
`ifdef ARB_TIMEOUT_EN
          else if (to_cnt_q == TO_LAST) begin
            wr_req_q <= 1'b0;
            err_q    <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
`endif
        end

        S_WR_XFER: begin
          // Burst is complete once the ACK window closes.
          if (!bus.SDRAM_WR_ACK) begin
            wr_ptr_q <= wr_ptr_q + PTR_BURST;
            level_q  <= level_q + LVL_BURST;
            state_q  <= S_DONE;
          end
        end

        S_RD_REQ: begin
          if (bus.SDRAM_RD_ACK) begin
            rd_req_q <= 1'b0;
            state_q  <= S_RD_XFER;
          end
`ifdef ARB_TIMEOUT_EN
          else if (to_cnt_q == TO_LAST) begin
            rd_req_q <= 1'b0;
            err_q    <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_IDLE;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
`endif
        end

        S_RD_XFER: begin
          if (!bus.SDRAM_RD_ACK) begin
            rd_ptr_q <= rd_ptr_q + PTR_BURST;
            level_q  <= level_q - LVL_BURST;
            state_q  <= S_DONE;
          end
        end

        S_DONE: begin
          last_grant_q <= cur_grant_q;
          busy_q       <= 1'b0;
          state_q      <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.SDRAM_WR_REQ  = wr_req_q;
  assign bus.SDRAM_RD_REQ  = rd_req_q;
  assign bus.SDRAM_ADDR_IN = addr_q;
  assign bus.LEVEL         = level_q;
  assign bus.BUSY          = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.ERR           = err_q;
`else
  assign bus.ERR           = 1'b0;
`endif

endmodule
